// File: rtl/io_conditioner_pkg.sv
// io_cond_pkg: shared constants, chord state type and counter sizing for io_conditioner
package io_cond_pkg;
  localparam int DEBOUNCE_SIM = 4;
  localparam int DEBOUNCE_HW = 500000;
  localparam int SYNC_DEFAULT = 2;
  typedef enum logic [1:0] {IDLE, HOLD, FIRED} chord_state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/io_conditioner_if.sv
// io_conditioner_if: raw board inputs and conditioned outputs of io_conditioner
interface io_conditioner_if #(
  parameter int NUM_KEYS = 2,
  parameter int SW_WIDTH = 10
);
  logic [NUM_KEYS-1:0] key_raw, key_level, key_press, key_release;
  logic [SW_WIDTH-1:0] sw_raw, sw_stable;
  logic sw_changed, chord_req;
  modport master (
    output key_raw, sw_raw,
    input key_level, key_press, key_release, sw_stable, sw_changed, chord_req
  );
  modport slave (
    input key_raw, sw_raw,
    output key_level, key_press, key_release, sw_stable, sw_changed, chord_req
  );
endinterface

// File: rtl/io_conditioner_debounce_cell.sv
// debounce_cell: synchroniser, whole-vector debounce counter, stable register and edge pulses
module debounce_cell import io_cond_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter logic [WIDTH-1:0] INVERT = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] cur, ahead;
  logic [CW-1:0] cnt;
  logic settle, take;
  assign cur = sync[SYNC_STAGES-1] ^ INVERT;
  assign ahead = sync[SYNC_STAGES-2] ^ INVERT;
  // a cycle counts only if the output differs from stable and the stage behind it agrees
  assign settle = (cur != stable) && (cur == ahead);
  assign take = settle && (cnt == LAST);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= INVERT;
      cnt <= '0;
      stable <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      sync[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      cnt <= (settle && !take) ? cnt + 1'b1 : '0;
      stable <= take ? cur : stable;
      rise <= take ? cur & ~stable : '0;
      fall <= take ? ~cur & stable : '0;
    end
endmodule

// File: rtl/io_conditioner.sv
// io_conditioner: debounced keys and switches plus a held-chord reset request
module io_conditioner import io_cond_pkg::*; #(
  parameter int NUM_KEYS = 2,
  parameter int SW_WIDTH = 10,
  parameter int SYNC_STAGES = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter logic [NUM_KEYS-1:0] CHORD_MASK = 2'b11,
  parameter int CHORD_HOLD = 8,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input logic Clk,
  input logic Reset,
  io_conditioner_if.slave io
);
  localparam int HW = cnt_width(CHORD_HOLD);
  localparam logic [HW-1:0] LAST = HW'(CHORD_HOLD - 1);
  chord_state_t state, next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [SW_WIDTH-1:0] sw_rise, sw_fall;
  logic held, fire;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT(KEY_ACTIVE_LOW)
    ) u_key (
      .Clk(Clk), .Reset(Reset), .raw(io.key_raw[i]), .stable(io.key_level[i]),
      .rise(io.key_press[i]), .fall(io.key_release[i])
    );
  end
  debounce_cell #(
    .WIDTH(SW_WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw (
    .Clk(Clk), .Reset(Reset), .raw(io.sw_raw), .stable(io.sw_stable),
    .rise(sw_rise), .fall(sw_fall)
  );
  assign io.sw_changed = |(sw_rise | sw_fall);
  assign held = &(io.key_level | ~CHORD_MASK);
  assign io.chord_req = fire;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= next;
      hold_cnt <= hold_next;
    end
  always_comb begin
    next = state;
    hold_next = '0;
    fire = 1'b0;
    case (state)
      IDLE: next = held ? HOLD : IDLE;
      HOLD: begin
        hold_next = hold_cnt + 1'b1;
        fire = held && (hold_cnt == LAST);
        next = !held ? IDLE : fire ? FIRED : HOLD;
      end
      FIRED: next = held ? FIRED : IDLE;
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_io_conditioner.sv
// tb_io_conditioner: directed checks of debounce, pulses and chord detection on two configurations
module tb_io_conditioner;
  logic Clk, Reset;
  int checks = 0, errors = 0;
  io_conditioner_if a ();
  io_conditioner_if #(.NUM_KEYS(4), .SW_WIDTH(16)) b ();
  io_conditioner u_dut (.Clk(Clk), .Reset(Reset), .io(a.slave));
  io_conditioner #(
    .NUM_KEYS(4), .SW_WIDTH(16), .CHORD_MASK(4'b1010), .DEBOUNCE_CYCLES(1)
  ) u_dut4 (.Clk(Clk), .Reset(Reset), .io(b.slave));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    Reset = 1'b0;
    a.key_raw = 2'b00;
    a.sw_raw = 10'h3FF;
    b.key_raw = 4'hF;
    b.sw_raw = 16'h0;
    repeat (3) begin
      cyc(1);
      chk("reset_outs", 32'({a.key_level, a.key_press, a.key_release, a.sw_stable, a.sw_changed, a.chord_req}), 0);
    end
    Reset = 1'b1;
    cyc(5);
    chk("t1_level_e5", 32'({a.key_level, a.sw_stable}), 0);
    cyc(1);
    chk("t1_level_e6", 32'(a.key_level), 2'b11);
    chk("t1_press_e6", 32'(a.key_press), 2'b11);
    chk("t1_sw_e6", 32'({a.sw_stable, a.sw_changed}), {10'h3FF, 1'b1});
    cyc(1);
    chk("t1_pulse_e7", 32'({a.key_press, a.sw_changed}), 0);
    a.key_raw = 2'b11;
    cyc(5);
    chk("t1_rel_e5", 32'(a.key_level), 2'b11);
    cyc(1);
    chk("t1_rel_e6", 32'({a.key_level, a.key_release, a.chord_req}), {2'b00, 2'b11, 1'b0});
    cyc(1);
    chk("t1_rel_e7", 32'(a.key_release), 0);
    a.key_raw = 2'b10;
    cyc(2);
    a.key_raw = 2'b11;
    repeat (10) begin
      cyc(1);
      chk("t2_glitch", 32'({a.key_level, a.key_press}), 0);
    end
    a.key_raw = 2'b10;
    cyc(5);
    chk("t2_press_e5", 32'(a.key_level), 0);
    cyc(1);
    chk("t2_press_e6", 32'({a.key_level, a.key_press}), {2'b01, 2'b01});
    cyc(1);
    chk("t2_press_e7", 32'(a.key_press), 0);
    cyc(3);
    a.key_raw = 2'b11;
    cyc(5);
    chk("t2_rel_e5", 32'(a.key_level), 2'b01);
    cyc(1);
    chk("t2_rel_e6", 32'({a.key_level, a.key_release}), {2'b00, 2'b01});
    cyc(1);
    chk("t2_rel_e7", 32'(a.key_release), 0);
    a.sw_raw = 10'h000;
    cyc(6);
    chk("t3_sw0", 32'({a.sw_stable, a.sw_changed}), {10'h000, 1'b1});
    cyc(1);
    a.sw_raw = 10'h003;
    cyc(6);
    chk("t3_sw3", 32'({a.sw_stable, a.sw_changed}), {10'h003, 1'b1});
    cyc(1);
    chk("t3_sw3_quiet", 32'(a.sw_changed), 0);
    for (int i = 0; i < 4; i++) begin
      a.sw_raw = (i % 2 == 0) ? 10'h023 : 10'h003;
      repeat (2) begin
        cyc(1);
        chk("t3_toggle", 32'({a.sw_stable, a.sw_changed}), {10'h003, 1'b0});
      end
    end
    a.sw_raw = 10'h023;
    repeat (5) begin
      cyc(1);
      chk("t3_settle", 32'({a.sw_stable, a.sw_changed}), {10'h003, 1'b0});
    end
    cyc(1);
    chk("t3_sw23", 32'({a.sw_stable, a.sw_changed}), {10'h023, 1'b1});
    cyc(1);
    chk("t3_sw23_quiet", 32'(a.sw_changed), 0);
    a.key_raw = 2'b00;
    cyc(6);
    chk("t4_both", 32'({a.key_level, a.key_press}), {2'b11, 2'b11});
    repeat (7) begin
      cyc(1);
      chk("t4_pre_chord", 32'(a.chord_req), 0);
    end
    cyc(1);
    chk("t4_chord", 32'(a.chord_req), 1);
    repeat (22) begin
      cyc(1);
      chk("t4_one_shot", 32'(a.chord_req), 0);
    end
    a.key_raw = 2'b10;
    cyc(6);
    chk("t4_cont_rel", 32'({a.key_level, a.key_release, a.chord_req}), {2'b01, 2'b10, 1'b0});
    cyc(2);
    a.key_raw = 2'b00;
    cyc(6);
    chk("t4_cont_press", 32'({a.key_level, a.key_press}), {2'b11, 2'b10});
    repeat (7) begin
      cyc(1);
      chk("t4_pre_chord2", 32'(a.chord_req), 0);
    end
    cyc(1);
    chk("t4_chord2", 32'(a.chord_req), 1);
    cyc(1);
    chk("t4_chord2_end", 32'(a.chord_req), 0);
    a.key_raw = 2'b11;
    cyc(6);
    chk("t5_released", 32'(a.key_level), 0);
    a.key_raw = 2'b00;
    cyc(5);
    a.key_raw = 2'b01;
    cyc(1);
    chk("t5_held", 32'(a.key_level), 2'b11);
    repeat (4) begin
      cyc(1);
      chk("t5_short_hold", 32'(a.chord_req), 0);
    end
    cyc(1);
    chk("t5_run_drop", 32'({a.key_level, a.chord_req}), {2'b10, 1'b0});
    repeat (10) begin
      cyc(1);
      chk("t5_no_chord", 32'(a.chord_req), 0);
    end
    a.key_raw = 2'b00;
    cyc(6);
    chk("t5_rehold", 32'({a.key_level, a.key_press}), {2'b11, 2'b01});
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    chk("t5_mid_reset", 32'({a.key_level, a.key_press, a.key_release, a.sw_stable, a.sw_changed, a.chord_req}), 0);
    Reset = 1'b1;
    cyc(5);
    chk("t5_post_e5", 32'({a.key_level, a.chord_req}), 0);
    cyc(1);
    chk("t5_post_e6", 32'({a.key_level, a.key_press}), {2'b11, 2'b11});
    repeat (7) begin
      cyc(1);
      chk("t5_post_pre_chord", 32'(a.chord_req), 0);
    end
    cyc(1);
    chk("t5_post_chord", 32'(a.chord_req), 1);
    a.key_raw = 2'b11;
    cyc(7);
    b.sw_raw = 16'hF0F0;
    cyc(2);
    chk("t6_sw_e2", 32'(b.sw_stable), 0);
    cyc(1);
    chk("t6_sw_e3", 32'({b.sw_stable, b.sw_changed}), {16'hF0F0, 1'b1});
    cyc(1);
    chk("t6_sw_quiet", 32'(b.sw_changed), 0);
    b.key_raw = 4'b1010;
    cyc(2);
    chk("t6_k02_e2", 32'(b.key_level), 0);
    cyc(1);
    chk("t6_k02_e3", 32'({b.key_level, b.key_press}), {4'b0101, 4'b0101});
    repeat (12) begin
      cyc(1);
      chk("t6_unmasked", 32'(b.chord_req), 0);
    end
    b.key_raw = 4'b0101;
    cyc(3);
    chk("t6_swap", 32'({b.key_level, b.key_press, b.key_release}), {4'b1010, 4'b1010, 4'b0101});
    repeat (7) begin
      cyc(1);
      chk("t6_pre_chord", 32'(b.chord_req), 0);
    end
    cyc(1);
    chk("t6_chord", 32'(b.chord_req), 1);
    cyc(1);
    chk("t6_chord_end", 32'(b.chord_req), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
